// File: rtl/rc5_key_expander_pkg.sv
// Shared RC5 definitions: magic constants, FSM encoding, and the
// table/key-size derivation helpers (also used by the cipher block).
package rc5_key_expander_pkg;

  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT_S = 3'd1,
    ST_MIX_A  = 3'd2,
    ST_MIX_B  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Table words T = 2*(R+1)
  function automatic int rc5_t(input int r);
    return 2 * (r + 1);
  endfunction

  // Key words C = max(1, ceil(8*B/W))
  function automatic int rc5_c(input int b, input int w);
    int c;
    c = (8 * b + w - 1) / w;
    return (c < 1) ? 1 : c;
  endfunction

  // Mix iterations N_MIX = 3*max(T,C)
  function automatic int rc5_nmix(input int t, input int c);
    return 3 * ((t > c) ? t : c);
  endfunction

  // Fixed left rotate by 3 used by the A half-step (pure wiring)
  function automatic logic [31:0] rotl3(input logic [31:0] x);
    return {x[28:0], x[31:29]};
  endfunction

endpackage

// File: rtl/rc5_key_expander_barrel.sv
// barrelShifter32: 32-bit rotate, five log stages.
// iDir = 0 rotates left, iDir = 1 rotates right (done as a left rotate by -iShift).
module barrelShifter32 (
  input  logic [31:0] iData,
  input  logic [4:0]  iShift,
  input  logic        iDir,
  output logic [31:0] oData
);

  logic [4:0]  w_amt;
  logic [31:0] w_st [0:5];

  assign w_amt    = iDir ? (5'd0 - iShift) : iShift;
  assign w_st[0]  = iData;

  for (genvar g = 0; g < 5; g++) begin : g_stage
    localparam int SH = 1 << g;
    assign w_st[g+1] = w_amt[g] ? {w_st[g][31-SH:0], w_st[g][31:32-SH]} : w_st[g];
  end

  assign oData = w_st[5];

endmodule

// File: rtl/rc5_key_expander.sv
// RC5 key expander: builds the T-word round-key table S from a B-byte key
// and serves it to the cipher through two registered read ports.
// Only W = 32 is supported (the data-dependent rotate is barrelShifter32).
module rc5_key_expander
  import rc5_key_expander_pkg::*;
#(
  parameter  int W        = 32,
  parameter  int R        = 12,
  parameter  int B        = 16,
  localparam int T        = rc5_t(R),
  localparam int C        = rc5_c(B, W),
  localparam int N_MIX    = rc5_nmix(T, C),
  localparam int T_LENGTH = $clog2(T),
  localparam int IDX_W    = $clog2(N_MIX),
  localparam int J_W      = (C > 1) ? $clog2(C) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [8*B-1:0]      iKey,
  input  logic [T_LENGTH-1:0] iS_address1,
  input  logic [T_LENGTH-1:0] iS_address2,
  output logic [W-1:0]        oS_sub_i1,
  output logic [W-1:0]        oS_sub_i2,
  output logic                oBusy,
  output logic                oDone
);

  state_t              r_state;
  logic [W-1:0]        r_S [T];
  logic [W-1:0]        r_L [C];
  logic [W-1:0]        r_A, r_B, r_sval;
  logic [T_LENGTH-1:0] r_k, r_i;
  logic [J_W-1:0]      r_j;
  logic [IDX_W-1:0]    r_cnt;
  logic                r_busy, r_done;

  logic [W-1:0]        w_a_new, w_ab, w_b_sum, w_b_new;

  // A half-step: fixed rotate by 3 of S[i] + A + B
  assign w_a_new = rotl3(r_S[r_i] + r_A + r_B);

  // B half-step: rotate L[j] + A + B left by (A + B) mod W
  assign w_ab    = r_A + r_B;
  assign w_b_sum = r_L[r_j] + w_ab;

  barrelShifter32 u_rot (
    .iData  (w_b_sum),
    .iShift (w_ab[4:0]),
    .iDir   (1'b0),
    .oData  (w_b_new)
  );

  assign oBusy = r_busy;
  assign oDone = r_done;

  // Key-schedule FSM: start/latch key, fill S with P+kQ, then 3*max(T,C) mix steps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_A     <= '0;
      r_B     <= '0;
      r_sval  <= '0;
      r_k     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_cnt   <= '0;
      for (int k = 0; k < T; k++) r_S[k] <= '0;
      for (int k = 0; k < C; k++) r_L[k] <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (iStart) begin
            for (int k = 0; k < C; k++) r_L[k] <= iKey[W*k +: W];
            r_k     <= '0;
            r_A     <= '0;
            r_B     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
            r_sval  <= P32;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_INIT_S;
          end
        end
        ST_INIT_S: begin
          r_S[r_k] <= r_sval;
          r_sval   <= r_sval + Q32;
          r_k      <= r_k + 1'b1;
          if (r_k == T_LENGTH'(T - 1)) r_state <= ST_MIX_A;
        end
        ST_MIX_A: begin
          r_S[r_i] <= w_a_new;
          r_A      <= w_a_new;
          r_state  <= ST_MIX_B;
        end
        ST_MIX_B: begin
          r_L[r_j] <= w_b_new;
          r_B      <= w_b_new;
          r_i      <= (r_i == T_LENGTH'(T - 1)) ? '0 : r_i + 1'b1;
          r_j      <= (r_j == J_W'(C - 1))      ? '0 : r_j + 1'b1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == IDX_W'(N_MIX - 1)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_MIX_A;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Two independent registered read ports; addresses past the table read 0
  always_ff @(posedge clk) begin
    if (rst) begin
      oS_sub_i1 <= '0;
      oS_sub_i2 <= '0;
    end else begin
      oS_sub_i1 <= ({1'b0, iS_address1} < (T_LENGTH+1)'(T)) ? r_S[iS_address1] : '0;
      oS_sub_i2 <= ({1'b0, iS_address2} < (T_LENGTH+1)'(T)) ? r_S[iS_address2] : '0;
    end
  end

endmodule
